// File: rtl/mem_pkg.sv
// Shared load/store encodings, responder FSM states and op classification helpers.
package mem_pkg;

  localparam logic [2:0] MEM_LW  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LHU = 3'b010;
  localparam logic [2:0] MEM_LB  = 3'b011;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_SW  = 3'b101;
  localparam logic [2:0] MEM_SH  = 3'b110;
  localparam logic [2:0] MEM_SB  = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
  endfunction

  function automatic size_t size_of(input logic [2:0] op);
    case (op)
      MEM_LW, MEM_SW:          return SZ_W;
      MEM_LH, MEM_LHU, MEM_SH: return SZ_H;
      default:                 return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: store byte-enables/aligned write word, load extraction with
// sign/zero extension, and the misalignment flag.
module dmem_lane
  import mem_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [4:0]  sh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign sh = {offset, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wword      = 32'h0;
    rdata      = 32'h0;
    misaligned = 1'b0;
    rbyte      = 8'(word >> sh);
    rhalf      = 16'(word >> sh);

    // Upper bits of wword beyond the enabled lanes are don't-care.
    case (size_of(mem_op))
      SZ_W: begin
        misaligned = (offset != 2'b00);
        be         = 4'b1111;
        wword      = wdata;
      end
      SZ_H: begin
        misaligned = offset[0];
        be         = 4'b0011 << offset;
        wword      = wdata << sh;
      end
      default: begin
        be    = 4'b0001 << offset;
        wword = wdata << sh;
      end
    endcase

    case (mem_op)
      MEM_LW:  rdata = word;
      MEM_LH:  rdata = {{16{rhalf[15]}}, rhalf};
      MEM_LHU: rdata = {16'h0, rhalf};
      MEM_LB:  rdata = {{24{rbyte[7]}}, rbyte};
      MEM_LBU: rdata = {24'h0, rbyte};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM, byte-enabled storage array and
// same-cycle misaligned-access reporting for the M-stage load/store port.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        resp_done,
  output logic        addr_err,
  output logic [31:0] badaddr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic ONE_WAIT  = (WAIT_STATES == 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [3:0]      be;
  logic [31:0]     wword;
  logic [31:0]     lane_rdata;
  logic            misaligned;
  logic            idle_req;
  logic            accept;
  logic            err;
  logic            complete;

  assign idx  = addr[AW+1:2];
  assign word = mem[idx];

  dmem_lane u_lane (
    .mem_op     (mem_op),
    .offset     (addr[1:0]),
    .wdata      (wdata),
    .word       (word),
    .be         (be),
    .wword      (wword),
    .rdata      (lane_rdata),
    .misaligned (misaligned)
  );

  // Everything is gated by rst so outputs collapse to reset values asynchronously.
  assign idle_req = rst && (state == IDLE) && req_valid;
  assign accept   = idle_req && !misaligned;
  assign err      = idle_req && misaligned;
  assign complete = rst && ((state == RESP) || (accept && ZERO_WAIT));

  assign stall     = rst && ((accept && !ZERO_WAIT) || (state == WAIT));
  assign resp_done = complete || err;
  assign addr_err  = err;
  assign badaddr   = err ? addr : 32'h0;
  assign rdata     = (complete && !is_store(mem_op)) ? lane_rdata : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !ZERO_WAIT) begin
            if (ONE_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(WAIT_STATES - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - CW'(1);
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is intentionally unreset; stores commit at the end of the completion cycle.
  always_ff @(posedge clk) begin
    if (complete && is_store(mem_op)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule
